// File: rtl/spi_result_collector_pkg.sv
// Shared types and constants for the SPI result collector.
package spi_collector_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_result_collector_if.sv
// SPI pins, run/flush controls and FIFO read side of the result collector.
interface spi_result_collector_if
    import spi_collector_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CNT_W = count_width(DEPTH);

    logic             mosi;
    logic             slave_select;
    logic             spi_clock;
    logic             finished;
    logic             clear;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             frame_error;
    logic             overflow;
    logic             run_done;
    logic [WIDTH-1:0] checksum;

    modport master (
        output mosi, slave_select, spi_clock, finished, clear, rd_en,
        input  rd_data, empty, full, count, frame_error, overflow, run_done, checksum
    );

    modport slave (
        input  mosi, slave_select, spi_clock, finished, clear, rd_en,
        output rd_data, empty, full, count, frame_error, overflow, run_done, checksum
    );
endinterface

// File: rtl/spi_result_collector_sync_fifo.sv
// First-word-fall-through FIFO; clear wins over pop but a same-cycle write lands in slot 0.
module sync_fifo
    import spi_collector_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          i_wr,
    input  logic [WIDTH-1:0]              i_wdata,
    input  logic                          i_pop,
    input  logic                          i_clear,
    output logic [WIDTH-1:0]              o_rdata,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [count_width(DEPTH)-1:0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_waddr;
    logic             w_pop;

    assign w_pop   = i_pop & ~o_empty & ~i_clear;
    assign w_waddr = i_clear ? '0 : r_wptr;

    always_ff @(posedge clock) begin
        if (i_wr) r_mem[w_waddr] <= i_wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_rptr  <= '0;
            r_wptr  <= i_wr ? PTR_W'(1) : '0;
            r_count <= i_wr ? CNT_W'(1) : '0;
        end else begin
            if (i_wr)  r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(i_wr) - CNT_W'(w_pop);
        end
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/spi_result_collector.sv
// SPI mode-0 slave that deserialises result frames into a FWFT FIFO.
// Optional running checksum of stored words under macro COLLECTOR_CHECKSUM_EN.
module spi_result_collector
    import spi_collector_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    spi_result_collector_if.slave bus
);
    localparam int BC_W = $clog2(WIDTH + 2);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(WIDTH);
    localparam logic [BC_W-1:0] BC_MAX  = BC_W'(WIDTH + 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic                   r_ss_d;
    logic                   r_sck_d;
    logic [WIDTH-1:0]       r_shift;
    logic [BC_W-1:0]        r_bit_cnt;
    logic                   r_frame_error;
    logic                   r_overflow;
    logic                   r_run_done;
    logic                   r_fin_pend;
    logic                   w_mosi, w_ss, w_sck;
    logic                   w_ss_fall, w_ss_rise, w_sck_rise;
    logic                   w_frame_bad;
    logic                   w_commit, w_pop, w_wr;
    logic                   w_empty, w_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_sck_sync  <= '0;
            r_ss_d      <= 1'b1;
            r_sck_d     <= 1'b0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], bus.slave_select};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.spi_clock};
            r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
            r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss       = r_ss_sync[SYNC_STAGES-1];
    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_ss_fall  = r_ss_d & ~w_ss;
    assign w_ss_rise  = ~r_ss_d & w_ss;
    assign w_sck_rise = ~r_sck_d & w_sck;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_bad = 1'b0;
        case (r_state)
            IDLE:   if (w_ss_fall) w_state_nxt = SHIFT;
            SHIFT: begin
                if (w_ss_rise) begin
                    if (r_bit_cnt == BC_FULL) begin
                        w_state_nxt = COMMIT;
                    end else begin
                        w_state_nxt = IDLE;
                        w_frame_bad = 1'b1;
                    end
                end
            end
            COMMIT: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= w_frame_bad;
            if (r_state == IDLE && w_ss_fall) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (r_state == SHIFT && w_sck_rise) begin
                r_shift <= {r_shift[WIDTH-2:0], w_mosi};
                if (r_bit_cnt != BC_MAX) r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end
        end
    end

    // A commit alongside clear always lands, since clear empties the FIFO that same edge.
    assign w_commit = (r_state == COMMIT);
    assign w_pop    = bus.rd_en & ~w_empty;
    assign w_wr     = w_commit & (~w_full | w_pop | bus.clear);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_run_done <= 1'b0;
            r_fin_pend <= 1'b0;
        end else if (bus.clear) begin
            r_overflow <= 1'b0;
            r_run_done <= 1'b0;
            r_fin_pend <= 1'b0;
        end else begin
            if (w_commit && !w_wr) r_overflow <= 1'b1;
            if (r_state == IDLE) begin
                if (bus.finished || r_fin_pend) r_run_done <= 1'b1;
                r_fin_pend <= 1'b0;
            end else if (bus.finished) begin
                r_fin_pend <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_wr    (w_wr),
        .i_wdata (r_shift),
        .i_pop   (bus.rd_en),
        .i_clear (bus.clear),
        .o_rdata (bus.rd_data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (bus.count)
    );

    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.frame_error = r_frame_error;
    assign bus.overflow    = r_overflow;
    assign bus.run_done    = r_run_done;

`ifdef COLLECTOR_CHECKSUM_EN
    logic [WIDTH-1:0] r_checksum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)         r_checksum <= '0;
        else if (bus.clear) r_checksum <= w_wr ? r_shift : '0;
        else if (w_wr)      r_checksum <= r_checksum + r_shift;
    end

    assign bus.checksum = r_checksum;
`else
    assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_spi_result_collector.sv
// Randomised bench for spi_result_collector against a queue-based reference model.
module tb_spi_result_collector;
    localparam int W    = 8;
    localparam int D    = 8;
    localparam int HALF = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    spi_result_collector_if #(.WIDTH(W), .DEPTH(D)) bus ();

    spi_result_collector #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] m_q[$];
    bit           m_ovf;
    bit           m_run_done;
    logic [W-1:0] m_csum;
    int           m_fe;
    int           fe_seen = 0;

    always @(posedge clock) if (bus.frame_error === 1'b1) fe_seen++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_ovf      = 0;
        m_run_done = 0;
        m_csum     = '0;
    endfunction

    function automatic void model_commit(input logic [W-1:0] word, input bit pop);
        if (pop && m_q.size() > 0) void'(m_q.pop_front());
        if (m_q.size() < D) begin
            m_q.push_back(word);
`ifdef COLLECTOR_CHECKSUM_EN
            m_csum = m_csum + word;
`endif
        end else begin
            m_ovf = 1;
        end
    endfunction

    task automatic check_state(input string tag);
        check_val({tag, ".count"}, 32'(bus.count), 32'(m_q.size()));
        check_val({tag, ".empty"}, 32'(bus.empty), 32'(m_q.size() == 0));
        check_val({tag, ".full"}, 32'(bus.full), 32'(m_q.size() == D));
        check_val({tag, ".rd_data"}, 32'(bus.rd_data), 32'(m_q.size() > 0 ? m_q[0] : 8'h00));
        check_val({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
        check_val({tag, ".run_done"}, 32'(bus.run_done), 32'(m_run_done));
        check_val({tag, ".checksum"}, 32'(bus.checksum), 32'(m_csum));
        check_val({tag, ".fe_pulses"}, 32'(fe_seen), 32'(m_fe));
    endtask

    task automatic spi_bits(input logic [15:0] data, input int nbits, input bit fin_mid);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.mosi = data[i];
            tick(HALF);
            bus.spi_clock = 1'b1;
            tick(HALF);
            bus.spi_clock = 1'b0;
            if (fin_mid && i == nbits / 2) begin
                bus.finished = 1'b1;
                tick(1);
                bus.finished = 1'b0;
                tick(2);
                check_val("run_done_mid", 32'(bus.run_done), 32'(m_run_done));
            end
        end
    endtask

    // Frame write lands four clocks after slave_select rises (two sync stages, edge, commit).
    task automatic send_frame(input logic [15:0] data, input int nbits, input bit pop_at_commit, input bit fin_mid);
        int pre;
        bus.slave_select = 1'b0;
        tick(HALF);
        spi_bits(data, nbits, fin_mid);
        tick(HALF);
        bus.slave_select = 1'b1;
        pre = m_q.size();
        if (nbits != W) begin
            m_fe++;
            tick(8);
        end else if (pop_at_commit) begin
            tick(3);
            bus.rd_en = 1'b1;
            tick(1);
            bus.rd_en = 1'b0;
            model_commit(data[W-1:0], 1'b1);
            tick(4);
        end else begin
            tick(3);
            check_val("lat_pre", 32'(bus.count), 32'(pre));
            tick(1);
            model_commit(data[W-1:0], 1'b0);
            check_val("lat_post", 32'(bus.count), 32'(m_q.size()));
            tick(4);
        end
        if (fin_mid) m_run_done = 1;
    endtask

    task automatic pop_one(input string tag);
        check_val(tag, 32'(bus.rd_data), 32'(m_q.size() > 0 ? m_q[0] : 8'h00));
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic clear_pulse();
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] vec3 [3];
        bus.mosi = 1'b0; bus.slave_select = 1'b1; bus.spi_clock = 1'b0;
        bus.finished = 1'b0; bus.clear = 1'b0; bus.rd_en = 1'b0;
        m_fe = 0;
        model_reset();
        #2 reset = 1'b0;
        tick(3);
        check_state("reset");
        reset = 1'b1;
        tick(2);

        send_frame(16'h06, 8, 0, 0);
        check_state("f06");
        pop_one("pop06");
        clear_pulse();

        vec3[0] = 8'h0C; vec3[1] = 8'h01; vec3[2] = 8'h15;
        for (int i = 0; i < 3; i++) send_frame(16'(vec3[i]), 8, 0, 0);
        check_state("three");
        for (int i = 0; i < 3; i++) pop_one("pop3");
        check_state("three_drained");
`ifdef COLLECTOR_CHECKSUM_EN
        check_val("csum22", 32'(bus.checksum), 32'h22);
`endif

        send_frame(16'h1F, 5, 0, 0);
        check_state("short5");
        send_frame(16'hA5, 8, 0, 0);
        check_state("fA5");

        clear_pulse();
        for (int i = 0; i < D + 1; i++) send_frame(16'(8'h30 + i), 8, 0, 0);
        check_state("overfill");

        clear_pulse();
        for (int i = 0; i < D; i++) send_frame(16'(8'h50 + i), 8, 0, 0);
        send_frame(16'h99, 8, 1, 0);
        check_state("pop_on_commit");
        for (int i = 0; i < D; i++) pop_one("drain");
        check_state("drained");

        clear_pulse();
        send_frame(16'h3C, 8, 0, 1);
        check_state("fin_mid");
        clear_pulse();
        check_state("fin_clr");
        bus.finished = 1'b1;
        tick(1);
        bus.finished = 1'b0;
        m_run_done = 1;
        tick(1);
        check_state("fin_idle");

        bus.slave_select = 1'b0;
        tick(HALF);
        spi_bits(16'h0B, 4, 0);
        reset = 1'b0;
        #1;
        model_reset();
        check_state("rst_mid");
        bus.slave_select = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(10);
        check_state("rst_after");

        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                pop_one("rnd_pop");
            end else if (r == 2) begin
                int v;
                v = $urandom_range(1, 9);
                send_frame(16'($urandom), (v >= W) ? v + 1 : v, 0, 0);
            end else if (r == 3) begin
                send_frame(16'($urandom_range(0, 255)), 8, 1, 0);
            end else if (r == 9) begin
                clear_pulse();
            end else begin
                send_frame(16'($urandom_range(0, 255)), 8, 0, 0);
            end
            check_state("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
